// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART transmit arbiter and its clients.
//   - FSM state encodings for the arbiter (idle / owned / draining)
//   - client index assignments on the arbiter's request vector
//   - ASCII control characters used by the text-producing clients
package uart_arb_pkg;

  // Arbiter FSM encodings
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StOwn   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  // Client slots on the request/grant vectors
  localparam int unsigned CL_DISPLAY = 0;
  localparam int unsigned CL_ECHO    = 1;
  localparam int unsigned CL_STATUS  = 2;

  // ASCII line control
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Picks the first set bit of elig_i scanning last_i+1, last_i+2, ... (wrapping), so the
// previous winner has lowest priority.
//   elig_i   : eligible requester vector
//   last_i   : index of the previous winner
//   winner_o : selected index (0 when valid_o is low)
//   valid_o  : at least one requester is eligible
module rr_pick #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    elig_i,
  input  logic [IdxW-1:0] last_i,
  output logic [IdxW-1:0] winner_o,
  output logic            valid_o
);

  always_comb begin
    int unsigned idx;
    logic        found;
    idx      = 0;
    found    = 1'b0;
    winner_o = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last_i) + k) % N;
      if (!found && elig_i[IdxW'(idx)]) begin
        found    = 1'b1;
        winner_o = IdxW'(idx);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx byte transmitter between several byte-stream clients.
// A client owns the UART for a whole message (req held high); ownership is granted
// round-robin. A watchdog reclaims the UART from an owner that holds it without sending.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   req_i           : per-client message request (level)
//   cl_start_i      : per-client byte strobe
//   cl_data_i       : per-client byte, client i on [8i+7:8i]
//   cl_busy_o       : per-client busy (always 1 for non-owners)
//   grant_o         : one-hot owner, or zero
//   tx_data_o/tx_start_o/tx_busy_i : uart_tx hookup
//   drop_err_o      : pulse, a non-owner strobed a byte
//   timeout_err_o   : pulse, watchdog released the owner
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_CLIENTS = 3,
  parameter int unsigned TIMEOUT   = 1_000_000,
  parameter int unsigned PEND_MAX  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_CLIENTS-1:0]   req_i,
  input  logic [N_CLIENTS-1:0]   cl_start_i,
  input  logic [8*N_CLIENTS-1:0] cl_data_i,
  output logic [N_CLIENTS-1:0]   cl_busy_o,
  output logic [N_CLIENTS-1:0]   grant_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_start_o,
  input  logic                   tx_busy_i,
  output logic                   drop_err_o,
  output logic                   timeout_err_o
);

  localparam int unsigned IdxW = $clog2(N_CLIENTS);
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
  localparam int unsigned PcW  = $clog2(PEND_MAX + 1);

  logic [1:0]           state_q, state_d;
  logic [IdxW-1:0]      last_q, last_d;
  logic [N_CLIENTS-1:0] grant_q, grant_d;
  logic [N_CLIENTS-1:0] lockout_q, lockout_d, lock_set;
  logic                 pend_q, pend_d;
  logic [PcW-1:0]       pcnt_q, pcnt_d;
  logic [WdW-1:0]       wdog_q, wdog_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 drop_q, drop_d;
  logic                 tmo_q, tmo_d;

  logic [N_CLIENTS-1:0] eligible;
  logic [IdxW-1:0]      pick_idx;
  logic                 pick_valid;
  logic                 owner_busy;
  logic                 accept;

  assign eligible = req_i & ~lockout_q;

  rr_pick #(
    .N    (N_CLIENTS),
    .IdxW (IdxW)
  ) u_pick (
    .elig_i   (eligible),
    .last_i   (last_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  // Owner is busy while uart_tx is busy or an issued start has not been acknowledged yet.
  assign owner_busy = tx_busy_i | pend_q;
  assign cl_busy_o  = ~grant_q | {N_CLIENTS{owner_busy}};
  // In OWN, last_q is the owner index.
  assign accept     = (state_q == StOwn) && cl_start_i[last_q] && !owner_busy;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    wdog_d     = wdog_q;
    tmo_d      = 1'b0;
    lock_set   = '0;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = {{(N_CLIENTS-1){1'b0}}, 1'b1} << pick_idx;
          last_d  = pick_idx;
          wdog_d  = '0;
          state_d = StOwn;
        end
      end
      StOwn: begin
        if (accept) begin
          wdog_d = '0;
        end else if (!owner_busy) begin
          if (wdog_q == WdW'(TIMEOUT - 1)) begin
            tmo_d    = 1'b1;
            lock_set = grant_q;
            wdog_d   = '0;
            state_d  = StDrain;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
        if (!req_i[last_q]) state_d = StDrain;
      end
      StDrain: begin
        if (!owner_busy) begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // A lockout survives only while the locked client keeps req high.
  assign lockout_d = (lockout_q | lock_set) & req_i;

  always_comb begin
    pend_d = pend_q;
    pcnt_d = pcnt_q;
    if (accept) begin
      pend_d = 1'b1;
      pcnt_d = '0;
    end else if (pend_q) begin
      if (tx_busy_i || pcnt_q == PcW'(PEND_MAX - 1)) begin
        pend_d = 1'b0;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  assign tx_start_d = accept;
  assign tx_data_d  = accept ? cl_data_i[{last_q, 3'b000} +: 8] : tx_data_q;
  assign drop_d     = |(cl_start_i & ~grant_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      last_q     <= IdxW'(N_CLIENTS - 1);
      grant_q    <= '0;
      lockout_q  <= '0;
      pend_q     <= 1'b0;
      pcnt_q     <= '0;
      wdog_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      drop_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      lockout_q  <= lockout_d;
      pend_q     <= pend_d;
      pcnt_q     <= pcnt_d;
      wdog_q     <= wdog_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      drop_q     <= drop_d;
      tmo_q      <= tmo_d;
    end
  end

  assign grant_o       = grant_q;
  assign tx_data_o     = tx_data_q;
  assign tx_start_o    = tx_start_q;
  assign drop_err_o    = drop_q;
  assign timeout_err_o = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a uart_tx model answers tx_start with a fixed busy window,
// stimulus pushes expected bytes/grants into queues, and a monitor pops and compares
// whenever the DUT issues a byte or changes to a new owner.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int unsigned N        = 3;
  localparam int unsigned TO       = 16;
  localparam int unsigned PM       = 4;
  localparam int unsigned UART_CYC = 5;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b1;
  logic [N-1:0]   req, cl_start, cl_busy, grant;
  logic [8*N-1:0] cl_data;
  logic [7:0]     tx_data;
  logic           tx_start, tx_busy, drop_err, timeout_err;

  int tests = 0;
  int fails = 0;

  logic [7:0]   exp_bytes[$];
  logic [N-1:0] exp_grants[$];
  logic         uart_dead = 1'b0;
  int           busy_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_CLIENTS (N),
    .TIMEOUT   (TO),
    .PEND_MAX  (PM)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_i         (req),
    .cl_start_i    (cl_start),
    .cl_data_i     (cl_data),
    .cl_busy_o     (cl_busy),
    .grant_o       (grant),
    .tx_data_o     (tx_data),
    .tx_start_o    (tx_start),
    .tx_busy_i     (tx_busy),
    .drop_err_o    (drop_err),
    .timeout_err_o (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // uart_tx model: busy for UART_CYC cycles, starting in the cycle tx_start is seen.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_start && !uart_dead) busy_cnt = UART_CYC;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = (busy_cnt > 0);
    end
  end

  // Monitor: byte stream and owner sequence against the scoreboard queues.
  initial begin
    logic [N-1:0] prev_grant;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        prev_grant = '0;
      end else begin
        if (tx_start) begin
          if (exp_bytes.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected tx_start: got byte %0h, expected none", tx_data);
          end else begin
            check("uart byte", 32'(tx_data), 32'(exp_bytes.pop_front()));
          end
        end
        if (grant != prev_grant && grant != '0) begin
          if (exp_grants.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected grant: got %b, expected none", grant);
          end else begin
            check("grant order", 32'(grant), 32'(exp_grants.pop_front()));
          end
        end
        prev_grant = grant;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "bench time limit");
  end

  task automatic wait_grant(input logic [N-1:0] g, input string name);
    for (int k = 0; k < 300; k++) begin
      if (grant === g) break;
      @(negedge clk);
    end
    check(name, 32'(grant), 32'(g));
  endtask

  task automatic do_reset();
    req      = '0;
    cl_start = '0;
    #1 rst_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  // Issue one byte from client i once it is not busy; optionally drop req the cycle after.
  task automatic send(input int i, input logic [7:0] b, input bit drop_after);
    for (int k = 0; k < 100 && cl_busy[i]; k++) @(negedge clk);
    check("cl_busy before start", 32'(cl_busy[i]), 32'd0);
    exp_bytes.push_back(b);
    cl_data[8*i +: 8] = b;
    cl_start[i] = 1'b1;
    @(negedge clk);
    cl_start[i] = 1'b0;
    if (drop_after) req[i] = 1'b0;
    check("tx_start latency", 32'(tx_start), 32'd1);
    check("tx_data", 32'(tx_data), 32'(b));
  endtask

  task automatic message(input int i, input logic [7:0] base, input bit rerise,
                         input bit drop_test);
    logic [N-1:0] g;
    int           j;
    g    = '0;
    g[i] = 1'b1;
    wait_grant(g, "grant owner");
    if (drop_test) begin
      j = (i + 1) % N;
      cl_data[8*j +: 8] = 8'h41;
      cl_start[j] = 1'b1;
      @(negedge clk);
      cl_start = '0;
      check("drop_err pulse", 32'(drop_err), 32'd1);
      check("no tx_start on drop", 32'(tx_start), 32'd0);
      @(negedge clk);
      check("drop_err one cycle", 32'(drop_err), 32'd0);
      cl_start = ~g;
      @(negedge clk);
      cl_start = '0;
      check("drop_err multi", 32'(drop_err), 32'd1);
      @(negedge clk);
      check("drop_err multi one cycle", 32'(drop_err), 32'd0);
    end
    for (int b = 0; b < 4; b++) send(i, base + 8'(b), 1'b0);
    req[i] = 1'b0;
    wait_grant('0, "release after message");
    check("released with uart idle", 32'(tx_busy), 32'd0);
    if (rerise) req[i] = 1'b1;
  endtask

  initial begin
    int k;
    req = '0; cl_start = '0; cl_data = '0;
    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    check("reset grant", 32'(grant), 32'd0);
    check("reset tx_start", 32'(tx_start), 32'd0);
    check("reset tx_data", 32'(tx_data), 32'd0);
    check("reset cl_busy", 32'(cl_busy), 32'b111);
    check("reset drop_err", 32'(drop_err), 32'd0);
    check("reset timeout_err", 32'(timeout_err), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    // Single client
    exp_grants.push_back(3'b001);
    req = 3'b001;
    @(negedge clk);
    check("single grant latency", 32'(grant), 32'b001);
    send(CL_DISPLAY, "M", 1'b0);
    send(CL_DISPLAY, "1", 1'b0);
    req[0] = 1'b0;
    @(negedge clk);
    check("grant held in drain", 32'(grant), 32'b001);
    check("uart busy in drain", 32'(tx_busy), 32'd1);
    wait_grant('0, "single release");
    check("single released idle", 32'(tx_busy), 32'd0);

    // Contention: order 0,1,2,0 from reset (last = 2)
    do_reset();
    exp_grants.push_back(3'b001);
    exp_grants.push_back(3'b010);
    exp_grants.push_back(3'b100);
    exp_grants.push_back(3'b001);
    req = 3'b111;
    message(CL_DISPLAY, 8'h30, 1'b1, 1'b0);
    message(CL_ECHO,    8'h40, 1'b0, 1'b1);
    message(CL_STATUS,  8'h50, 1'b0, 1'b0);
    message(CL_DISPLAY, 8'h60, 1'b0, 1'b0);

    // Watchdog
    do_reset();
    exp_grants.push_back(3'b001);
    exp_grants.push_back(3'b010);
    req = 3'b011;
    @(negedge clk);
    check("wdog grant", 32'(grant), 32'b001);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (timeout_err) break;
    end
    check("timeout cycle", 32'(k), 32'(TO));
    @(negedge clk);
    check("timeout one cycle", 32'(timeout_err), 32'd0);
    check("grant after timeout", 32'(grant), 32'd0);
    @(negedge clk);
    check("next owner after timeout", 32'(grant), 32'b010);
    req[1] = 1'b0;
    wait_grant('0, "release client 1");
    repeat (6) @(negedge clk);
    check("lockout holds", 32'(grant), 32'd0);
    req[0] = 1'b0;
    @(negedge clk);
    exp_grants.push_back(3'b001);
    req[0] = 1'b1;
    @(negedge clk);
    check("lockout cleared", 32'(grant), 32'b001);
    req = '0;
    wait_grant('0, "release after lockout");

    // Drop req the cycle after start, then in the same cycle as start
    exp_grants.push_back(3'b100);
    req = 3'b100;
    wait_grant(3'b100, "grant status");
    send(CL_STATUS, CR, 1'b1);
    @(negedge clk);
    check("grant held with byte in flight", 32'(grant), 32'b100);
    wait_grant('0, "release after in-flight");
    check("released after busy fell", 32'(tx_busy), 32'd0);
    exp_grants.push_back(3'b010);
    req = 3'b010;
    wait_grant(3'b010, "grant echo");
    for (int w = 0; w < 100 && cl_busy[1]; w++) @(negedge clk);
    exp_bytes.push_back(LF);
    cl_data[15:8] = LF;
    cl_start[1] = 1'b1;
    req[1] = 1'b0;
    @(negedge clk);
    cl_start = '0;
    check("start with req fall issued", 32'(tx_start), 32'd1);
    check("start with req fall data", 32'(tx_data), 32'(LF));
    @(negedge clk);
    check("drain holds grant", 32'(grant), 32'b010);
    wait_grant('0, "release after simultaneous");

    // Reset mid-message, then arbitration restarts from client 0
    exp_grants.push_back(3'b001);
    req = 3'b001;
    wait_grant(3'b001, "grant before reset");
    exp_bytes.push_back("Z");
    cl_data[7:0] = "Z";
    cl_start[0] = 1'b1;
    @(negedge clk);
    cl_start = '0;
    check("issued before reset", 32'(tx_start), 32'd1);
    check("pend before reset", 32'(cl_busy[0]), 32'd1);
    #1 rst_ni = 1'b0;
    @(negedge clk);
    check("mid reset grant", 32'(grant), 32'd0);
    check("mid reset tx_start", 32'(tx_start), 32'd0);
    check("mid reset cl_busy", 32'(cl_busy), 32'b111);
    req = 3'b101;
    exp_grants.push_back(3'b001);
    rst_ni = 1'b1;
    @(negedge clk);
    check("post reset winner", 32'(grant), 32'b001);

    // tx_busy never rises: pend releases after PEND_MAX cycles
    uart_dead = 1'b1;
    send(CL_DISPLAY, "P", 1'b0);
    for (k = 0; k < 20 && cl_busy[0]; k++) @(negedge clk);
    check("pend timeout", 32'(k), 32'(PM));
    uart_dead = 1'b0;
    req = '0;
    wait_grant('0, "final release");

    repeat (3) @(negedge clk);
    check("bytes outstanding", 32'(exp_bytes.size()), 32'd0);
    check("grants outstanding", 32'(exp_grants.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
